csr_ring_node: RTL and testbench

CSR_RING_NODE -- requirements
Module: csr_ring_node

---
 rtl/csr_ring_node.sv | 233 +++++++++++++++++++++++
 tb/tb_csr_ring_node.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_ring_node.sv
`default_nettype none
// ============================================================================
// Module   : csr_ring_node
// Brief    : CSR ring stop. Decodes local read/write packets onto a function
//            port, forwards foreign beats through an 8-deep FIFO, and injects
//            responses.
// Revision : 1.0 - initial release
// ============================================================================
module csr_ring_node #(
    parameter logic [15:0] ADDRESS_MASK   = 16'h8000,
    parameter logic [15:0] ADDRESS_SELECT = 16'h8000
) (
    input  logic        core_clk83,
    input  logic        reset_n,
    input  logic [3:0]  ring_ctl_in,
    input  logic [15:0] ring_data_in,
    output logic [3:0]  ring_ctl_out,
    output logic [15:0] ring_data_out,
    output logic        func_wr_valid,
    output logic        func_rd_valid,
    output logic [15:0] func_address,
    output logic [63:0] func_wr_data,
    input  logic        func_ack,
    input  logic [63:0] func_rd_data
);

    localparam logic [3:0] c_ctl_idle     = 4'd0;
    localparam logic [3:0] c_ctl_rd_req   = 4'd1;
    localparam logic [3:0] c_ctl_wr_req   = 4'd2;
    localparam logic [3:0] c_ctl_data     = 4'd3;
    localparam logic [3:0] c_ctl_rd_rsp   = 4'd4;
    localparam logic [3:0] c_ctl_wr_rsp   = 4'd5;
    localparam int unsigned c_fifo_depth  = 8;
    localparam logic [7:0] c_timeout_last = 8'd254;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_WDATA = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        INJ_WAIT = 3'd4,
        INJECT   = 3'd5
    } rx_state_t;

    rx_state_t   r_state;
    logic [1:0]  r_beat_cnt;
    logic [47:0] r_wbuf;
    logic [63:0] r_rdata;
    logic        r_is_read;
    logic [7:0]  r_to_cnt;
    logic [2:0]  r_inj_idx;
    logic [2:0]  r_drop_cnt;

    logic [19:0] r_fifo_mem [c_fifo_depth];
    logic [2:0]  r_wr_ptr;
    logic [2:0]  r_rd_ptr;
    logic [3:0]  r_fifo_cnt;

    logic        w_is_hdr;
    logic        w_is_data;
    logic        w_local_hdr;
    logic        w_rx_free;
    logic        w_take_hdr;
    logic        w_wdata_beat;
    logic        w_drop_data;
    logic        w_pass;
    logic        w_injecting;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_pop;
    logic        w_push;
    logic        w_bypass;
    logic        w_inj_last;
    logic [3:0]  w_inj_ctl;
    logic [15:0] w_inj_data;

    assign w_is_hdr     = (ring_ctl_in == c_ctl_rd_req) || (ring_ctl_in == c_ctl_wr_req);
    assign w_is_data    = (ring_ctl_in == c_ctl_data);
    assign w_local_hdr  = w_is_hdr && ((ring_data_in & ADDRESS_MASK) == ADDRESS_SELECT);
    // A non-DATA beat aborts a partial write, so that beat is decoded as if idle.
    assign w_rx_free    = (r_state == RX_IDLE) || ((r_state == RX_WDATA) && !w_is_data);
    assign w_take_hdr   = w_local_hdr && w_rx_free;
    assign w_wdata_beat = (r_state == RX_WDATA) && w_is_data;
    assign w_drop_data  = w_is_data && (r_drop_cnt != 3'd0);
    assign w_pass       = (ring_ctl_in != c_ctl_idle) && !w_local_hdr && !w_wdata_beat && !w_drop_data;

    assign w_injecting  = (r_state == INJECT);
    assign w_fifo_empty = (r_fifo_cnt == 4'd0);
    assign w_fifo_full  = (r_fifo_cnt == 4'd8);
    assign w_pop        = !w_injecting && !w_fifo_empty;
    assign w_push       = w_pass && !w_fifo_full && (w_injecting || !w_fifo_empty);
    assign w_bypass     = w_pass && !w_injecting && w_fifo_empty;
    assign w_inj_last   = r_is_read ? (r_inj_idx == 3'd4) : 1'b1;

    always_comb begin
        w_inj_ctl  = c_ctl_data;
        w_inj_data = 16'h0;
        case (r_inj_idx)
            3'd0: begin
                w_inj_ctl  = r_is_read ? c_ctl_rd_rsp : c_ctl_wr_rsp;
                w_inj_data = func_address;
            end
            3'd1:    w_inj_data = r_rdata[15:0];
            3'd2:    w_inj_data = r_rdata[31:16];
            3'd3:    w_inj_data = r_rdata[47:32];
            default: w_inj_data = r_rdata[63:48];
        endcase
    end

    always_ff @(posedge core_clk83) begin
        if (!reset_n) begin
            r_wr_ptr   <= 3'd0;
            r_rd_ptr   <= 3'd0;
            r_fifo_cnt <= 4'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {ring_ctl_in, ring_data_in};
                r_wr_ptr             <= r_wr_ptr + 3'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 4'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 4'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge core_clk83) begin
        if (!reset_n) begin
            ring_ctl_out  <= 4'h0;
            ring_data_out <= 16'h0;
        end else if (w_injecting) begin
            ring_ctl_out  <= w_inj_ctl;
            ring_data_out <= w_inj_data;
        end else if (w_pop) begin
            {ring_ctl_out, ring_data_out} <= r_fifo_mem[r_rd_ptr];
        end else if (w_bypass) begin
            ring_ctl_out  <= ring_ctl_in;
            ring_data_out <= ring_data_in;
        end else begin
            ring_ctl_out  <= c_ctl_idle;
            ring_data_out <= 16'h0;
        end
    end

    always_ff @(posedge core_clk83) begin
        if (!reset_n) begin
            r_state       <= RX_IDLE;
            r_beat_cnt    <= 2'd0;
            r_wbuf        <= 48'h0;
            r_rdata       <= 64'h0;
            r_is_read     <= 1'b0;
            r_to_cnt      <= 8'd0;
            r_inj_idx     <= 3'd0;
            r_drop_cnt    <= 3'd0;
            func_wr_valid <= 1'b0;
            func_rd_valid <= 1'b0;
            func_address  <= 16'h0;
            func_wr_data  <= 64'h0;
        end else begin
            func_wr_valid <= 1'b0;
            func_rd_valid <= 1'b0;

            // Local writes refused while busy take their four DATA beats with them.
            if (w_local_hdr && !w_rx_free && (ring_ctl_in == c_ctl_wr_req)) begin
                r_drop_cnt <= 3'd4;
            end else if (w_drop_data) begin
                r_drop_cnt <= r_drop_cnt - 3'd1;
            end else if (!w_is_data) begin
                r_drop_cnt <= 3'd0;
            end

            if (w_take_hdr) begin
                func_address <= ring_data_in;
                r_is_read    <= (ring_ctl_in == c_ctl_rd_req);
                r_beat_cnt   <= 2'd0;
                r_state      <= (ring_ctl_in == c_ctl_rd_req) ? ISSUE : RX_WDATA;
            end else begin
                case (r_state)
                    RX_WDATA: begin
                        if (w_is_data) begin
                            if (r_beat_cnt == 2'd3) begin
                                func_wr_valid <= 1'b1;
                                func_wr_data  <= {ring_data_in, r_wbuf};
                                r_state       <= INJ_WAIT;
                            end else begin
                                r_wbuf     <= {ring_data_in, r_wbuf[47:16]};
                                r_beat_cnt <= r_beat_cnt + 2'd1;
                            end
                        end else begin
                            r_state <= RX_IDLE;
                        end
                    end
                    ISSUE: begin
                        func_rd_valid <= 1'b1;
                        r_to_cnt      <= 8'd0;
                        r_state       <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (func_ack) begin
                            r_rdata <= func_rd_data;
                            r_state <= INJ_WAIT;
                        end else if (r_to_cnt == c_timeout_last) begin
                            r_rdata <= 64'h0;
                            r_state <= INJ_WAIT;
                        end else begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                    end
                    INJ_WAIT: begin
                        if (w_fifo_empty && (ring_ctl_in == c_ctl_idle)) begin
                            r_inj_idx <= 3'd0;
                            r_state   <= INJECT;
                        end
                    end
                    INJECT: begin
                        if (w_inj_last) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_inj_idx <= r_inj_idx + 3'd1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_ring_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_ring_node
// Brief    : Directed self-checking bench for csr_ring_node.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_ring_node;

    logic        core_clk83 = 1'b0;
    logic        reset_n    = 1'b0;
    logic [3:0]  ring_ctl_in  = 4'h0;
    logic [15:0] ring_data_in = 16'h0;
    logic [3:0]  ring_ctl_out;
    logic [15:0] ring_data_out;
    logic        func_wr_valid;
    logic        func_rd_valid;
    logic [15:0] func_address;
    logic [63:0] func_wr_data;
    logic        func_ack;
    logic [63:0] func_rd_data = 64'h0;
    logic        ack_tie      = 1'b0;

    assign func_ack = ack_tie & func_rd_valid;

    csr_ring_node dut (
        .core_clk83    (core_clk83),
        .reset_n       (reset_n),
        .ring_ctl_in   (ring_ctl_in),
        .ring_data_in  (ring_data_in),
        .ring_ctl_out  (ring_ctl_out),
        .ring_data_out (ring_data_out),
        .func_wr_valid (func_wr_valid),
        .func_rd_valid (func_rd_valid),
        .func_address  (func_address),
        .func_wr_data  (func_wr_data),
        .func_ack      (func_ack),
        .func_rd_data  (func_rd_data)
    );

    always #5 core_clk83 = ~core_clk83;

    typedef struct {
        logic [3:0]  ctl;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [3:0]  ctl;
        logic [15:0] data;
        logic [3:0]  exp_ctl;
        logic [15:0] exp_data;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cyc = 0;
    logic [15:0] rd_addr;
    logic [15:0] wr_addr;
    logic [63:0] wr_data_seen;
    beat_t       q_beats[$];
    int          q_cyc[$];
    vec_t        vecs[9];

    // Observe outputs mid-cycle, away from the active edge.
    always @(negedge core_clk83) begin
        cyc++;
        if (func_rd_valid) begin
            rd_cnt++;
            rd_addr = func_address;
            rd_cyc  = cyc;
        end
        if (func_wr_valid) begin
            wr_cnt++;
            wr_addr      = func_address;
            wr_data_seen = func_wr_data;
        end
        if (ring_ctl_out != 4'h0) begin
            q_beats.push_back('{ring_ctl_out, ring_data_out});
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input string name, input int idx, input logic [3:0] c, input logic [15:0] d);
        checks++;
        if (idx >= q_beats.size()) begin
            errors++;
            $display("FAIL %s[%0d]: got no beat expected %h/%h", name, idx, c, d);
        end else if (q_beats[idx].ctl !== c || q_beats[idx].data !== d) begin
            errors++;
            $display("FAIL %s[%0d]: got %h/%h expected %h/%h", name, idx,
                     q_beats[idx].ctl, q_beats[idx].data, c, d);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [15:0] d);
        ring_ctl_in  = c;
        ring_data_in = d;
        @(posedge core_clk83);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 16'h0);
    endtask

    task automatic clear_mon();
        q_beats.delete();
        q_cyc.delete();
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"},     ring_ctl_out,  4'h0);
        check({tag, "_data"},    ring_data_out, 16'h0);
        check({tag, "_wr_vld"},  func_wr_valid, 1'b0);
        check({tag, "_rd_vld"},  func_rd_valid, 1'b0);
        check({tag, "_addr"},    func_address,  16'h0);
        check({tag, "_wr_data"}, func_wr_data,  64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'h0, 16'h0000, 4'h0, 16'h0000};
        vecs[1] = '{4'h1, 16'h0005, 4'h1, 16'h0005};
        vecs[2] = '{4'h3, 16'habcd, 4'h3, 16'habcd};
        vecs[3] = '{4'h2, 16'h7fff, 4'h2, 16'h7fff};
        vecs[4] = '{4'h4, 16'h1234, 4'h4, 16'h1234};
        vecs[5] = '{4'h5, 16'h8001, 4'h5, 16'h8001};
        vecs[6] = '{4'h6, 16'h8000, 4'h6, 16'h8000};
        vecs[7] = '{4'hf, 16'hffff, 4'hf, 16'hffff};
        vecs[8] = '{4'h3, 16'h0001, 4'h3, 16'h0001};

        idle(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle(2);

        // Foreign traffic passes through with one cycle of latency.
        clear_mon();
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].ctl, vecs[i].data);
            check($sformatf("vec%0d_out", i), {ring_ctl_out, ring_data_out},
                  {vecs[i].exp_ctl, vecs[i].exp_data});
        end
        idle(2);
        check("vec_no_strobe", rd_cnt + wr_cnt, 0);

        // Local read with immediate ack.
        clear_mon();
        ack_tie      = 1'b1;
        func_rd_data = 64'h1122334455667788;
        step(4'h1, 16'h8001);
        idle(20);
        check("rd_strobes", rd_cnt, 1);
        check("rd_addr", rd_addr, 16'h8001);
        check("rd_no_wr", wr_cnt, 0);
        check("rd_beats", q_beats.size(), 5);
        expect_beat("rd", 0, 4'h4, 16'h8001);
        expect_beat("rd", 1, 4'h3, 16'h7788);
        expect_beat("rd", 2, 4'h3, 16'h5566);
        expect_beat("rd", 3, 4'h3, 16'h3344);
        expect_beat("rd", 4, 4'h3, 16'h1122);
        if (q_beats.size() == 5) begin
            check("rd_contig", q_cyc[4] - q_cyc[0], 4);
            // Strobe/ack cycle, capture into INJ_WAIT, INJECT, then beat.
            check("rd_latency", q_cyc[0] - rd_cyc, 3);
        end

        // Local write.
        clear_mon();
        step(4'h2, 16'h8003);
        step(4'h3, 16'hbeef);
        step(4'h3, 16'hdead);
        step(4'h3, 16'h0000);
        step(4'h3, 16'h1234);
        idle(10);
        check("wr_strobes", wr_cnt, 1);
        check("wr_data", wr_data_seen, 64'h12340000deadbeef);
        check("wr_addr", wr_addr, 16'h8003);
        check("wr_no_rd", rd_cnt, 0);
        check("wr_beats", q_beats.size(), 1);
        expect_beat("wr", 0, 4'h5, 16'h8003);

        // Partial write aborted by a local read header, which is then served.
        clear_mon();
        func_rd_data = 64'h0badf00dcafe5a5a;
        step(4'h2, 16'h8004);
        step(4'h3, 16'h0001);
        step(4'h3, 16'h0002);
        step(4'h1, 16'h8006);
        idle(20);
        check("abort_no_wr", wr_cnt, 0);
        check("abort_rd_strobes", rd_cnt, 1);
        check("abort_rd_addr", rd_addr, 16'h8006);
        check("abort_beats", q_beats.size(), 5);
        expect_beat("abort", 0, 4'h4, 16'h8006);
        expect_beat("abort", 1, 4'h3, 16'h5a5a);
        expect_beat("abort", 4, 4'h3, 16'h0bad);

        // Read timeout; a local write arriving meanwhile is dropped with its data.
        clear_mon();
        ack_tie      = 1'b0;
        func_rd_data = 64'hffffffffffffffff;
        step(4'h1, 16'h8002);
        idle(3);
        step(4'h2, 16'h8009);
        for (int i = 1; i <= 4; i++) step(4'h3, 16'(i));
        idle(300);
        check("to_rd_strobes", rd_cnt, 1);
        check("to_no_wr", wr_cnt, 0);
        check("to_beats", q_beats.size(), 5);
        expect_beat("to", 0, 4'h4, 16'h8002);
        for (int i = 1; i <= 4; i++) expect_beat("to", i, 4'h3, 16'h0000);
        // 255 unacknowledged cycles, then INJ_WAIT and INJECT.
        if (q_beats.size() > 0) check("to_latency", q_cyc[0] - rd_cyc, 257);

        // Foreign packet arriving during response injection.
        clear_mon();
        ack_tie      = 1'b1;
        func_rd_data = 64'h1122334455667788;
        step(4'h1, 16'h8001);
        idle(3);
        step(4'h2, 16'h1234);
        step(4'h3, 16'h0001);
        step(4'h3, 16'h0002);
        step(4'h3, 16'h0003);
        step(4'h3, 16'h0004);
        step(4'h6, 16'h00ff);
        idle(20);
        check("mix_beats", q_beats.size(), 11);
        expect_beat("mix", 0,  4'h4, 16'h8001);
        expect_beat("mix", 1,  4'h3, 16'h7788);
        expect_beat("mix", 2,  4'h3, 16'h5566);
        expect_beat("mix", 3,  4'h3, 16'h3344);
        expect_beat("mix", 4,  4'h3, 16'h1122);
        expect_beat("mix", 5,  4'h2, 16'h1234);
        expect_beat("mix", 6,  4'h3, 16'h0001);
        expect_beat("mix", 7,  4'h3, 16'h0002);
        expect_beat("mix", 8,  4'h3, 16'h0003);
        expect_beat("mix", 9,  4'h3, 16'h0004);
        expect_beat("mix", 10, 4'h6, 16'h00ff);
        if (q_beats.size() == 11) check("mix_contig", q_cyc[10] - q_cyc[0], 10);

        // Reset in the middle of a local write.
        clear_mon();
        step(4'h2, 16'h8005);
        step(4'h3, 16'haaaa);
        step(4'h3, 16'hbbbb);
        reset_n = 1'b0;
        step(4'h0, 16'h0000);
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        idle(20);
        check("midrst_no_wr", wr_cnt, 0);
        check("midrst_beats", q_beats.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
